// File: rtl/drive_ramp_sched.sv
// Speed/gear sequencer between rpm_ctrl and dc_pwm_gen: ramps the applied level toward
// the request, brings the drive to rest and dwells before committing a gear, stops on estop.
module drive_ramp_sched #(
   parameter int RAMP_TICKS  = 50,
   parameter int DWELL_TICKS = 200,
   parameter int MAX_LEVEL   = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] target_level,
   input  logic [2:0] gear_req,
   input  logic       estop,
   output logic [3:0] speed_out,
   output logic [2:0] gear_out,
   output logic [2:0] state_out,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_RAMP     = 3'd2,
      ST_SHIFT_DN = 3'd3,
      ST_DWELL    = 3'd4,
      ST_ESTOP    = 3'd5
   } state_e;

   // One counter serves both the step cadence and the dwell, so size it for the longer.
   localparam int TICK_MAX = (RAMP_TICKS > DWELL_TICKS) ? RAMP_TICKS : DWELL_TICKS;
   localparam int TICK_W   = $clog2(TICK_MAX + 1);
   localparam logic [TICK_W-1:0] RAMP_LAST  = TICK_W'(RAMP_TICKS - 1);
   localparam logic [TICK_W-1:0] DWELL_LAST = TICK_W'(DWELL_TICKS - 1);
   localparam logic [3:0]        MAX_LVL    = 4'(MAX_LEVEL);

   state_e            state_q, state_d;
   logic [3:0]        speed_q, speed_d;
   logic [2:0]        gear_q, gear_d;
   logic [2:0]        pend_q, pend_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic              busy_q, busy_d;

   logic [3:0] tgt;
   logic       ramp_step;
   logic       dwell_done;

   assign tgt        = (target_level > MAX_LVL) ? MAX_LVL : target_level;
   assign ramp_step  = (tick_q == RAMP_LAST);
   assign dwell_done = (tick_q == DWELL_LAST);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d = state_q;
      speed_d = speed_q;
      gear_d  = gear_q;
      pend_d  = pend_q;
      tick_d  = '0;

      if (estop) begin
         state_d = ST_ESTOP;
         speed_d = '0;
      end else begin
         case (state_q)
            ST_ESTOP: state_d = ST_IDLE;

            ST_IDLE, ST_RUN, ST_RAMP: begin
               if (gear_req != gear_q) begin
                  pend_d  = gear_req;
                  state_d = (speed_q == '0) ? ST_DWELL : ST_SHIFT_DN;
               end else if (state_q == ST_IDLE) begin
                  if (tgt != '0) state_d = ST_RAMP;
               end else if (state_q == ST_RUN) begin
                  if (tgt != speed_q) state_d = ST_RAMP;
               end else if (ramp_step) begin
                  // Direction is re-evaluated at every step, so a new target just redirects.
                  if (tgt > speed_q)      speed_d = speed_q + 4'd1;
                  else if (tgt < speed_q) speed_d = speed_q - 4'd1;
                  if (speed_d == tgt) state_d = (tgt == '0) ? ST_IDLE : ST_RUN;
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end

            ST_SHIFT_DN: begin
               pend_d = gear_req;
               if (ramp_step) begin
                  speed_d = (speed_q != '0) ? speed_q - 4'd1 : '0;
                  if (speed_d == '0) state_d = ST_DWELL;
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end

            ST_DWELL: begin
               pend_d  = gear_req;
               speed_d = '0;
               if (dwell_done) begin
                  gear_d  = pend_q;
                  state_d = (tgt != '0) ? ST_RAMP : ST_IDLE;
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end

            default: state_d = ST_IDLE;
         endcase
      end

      if (state_d != state_q) tick_d = '0;

      busy_d = (state_d == ST_RAMP) || (state_d == ST_SHIFT_DN) ||
               (state_d == ST_DWELL) || (state_d == ST_ESTOP);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         speed_q <= '0;
         gear_q  <= '0;
         pend_q  <= '0;
         tick_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         speed_q <= speed_d;
         gear_q  <= gear_d;
         pend_q  <= pend_d;
         tick_q  <= tick_d;
         busy_q  <= busy_d;
      end
   end

   assign speed_out = speed_q;
   assign gear_out  = gear_q;
   assign state_out = state_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_drive_ramp_sched.sv
// Bench for drive_ramp_sched: two instances (ceiling 15 and 12) checked every cycle
// against a timestamp-based behavioural model, plus literal checkpoints.
module tb_drive_ramp_sched;

   localparam int RT = 4;
   localparam int DT = 8;
   localparam int S_IDLE = 0, S_RUN = 1, S_RAMP = 2, S_SHIFT = 3, S_DWELL = 4, S_ESTOP = 5;

   typedef struct {
      int st;
      int spd;
      int gear;
      int pend;
      int entry;   // cycle index of the edge that entered the current state
   } mdl_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [3:0] target_level;
   logic [2:0] gear_req;
   logic       estop;
   logic [3:0] speed_a, speed_b;
   logic [2:0] gear_a, gear_b, state_a, state_b;
   logic       busy_a, busy_b;

   int   n_cmp = 0;
   int   n_fail = 0;
   int   now = 0;
   mdl_t ma, mb;

   drive_ramp_sched #(.RAMP_TICKS(RT), .DWELL_TICKS(DT), .MAX_LEVEL(15)) dut_a (
      .clk(clk), .rst_n(rst_n), .target_level(target_level), .gear_req(gear_req),
      .estop(estop), .speed_out(speed_a), .gear_out(gear_a), .state_out(state_a), .busy(busy_a)
   );

   drive_ramp_sched #(.RAMP_TICKS(RT), .DWELL_TICKS(DT), .MAX_LEVEL(12)) dut_b (
      .clk(clk), .rst_n(rst_n), .target_level(target_level), .gear_req(gear_req),
      .estop(estop), .speed_out(speed_b), .gear_out(gear_b), .state_out(state_b), .busy(busy_b)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, now, act, exp);
      end
   endtask

   // Steps happen every RT cycles after entering a stepping state; dwell ends DT cycles in.
   function automatic mdl_t mstep(input mdl_t m, input int maxl, input int t,
                                  input logic rs, input int tl, input int gr, input logic es);
      mdl_t n;
      int   tgt;
      int   el;
      n   = m;
      tgt = (tl > maxl) ? maxl : tl;
      el  = t - m.entry;
      if (!rs) begin
         n = '{S_IDLE, 0, 0, 0, t};
         return n;
      end
      if (es) begin
         n.st  = S_ESTOP;
         n.spd = 0;
      end else if (m.st == S_ESTOP) begin
         n.st = S_IDLE;
      end else if (m.st == S_DWELL) begin
         n.pend = gr;
         if (el == DT) begin
            n.gear = m.pend;
            n.st   = (tgt != 0) ? S_RAMP : S_IDLE;
         end
      end else if (m.st == S_SHIFT) begin
         n.pend = gr;
         if (el % RT == 0) begin
            n.spd = (m.spd > 0) ? m.spd - 1 : 0;
            if (n.spd == 0) n.st = S_DWELL;
         end
      end else if (gr != m.gear) begin
         n.pend = gr;
         n.st   = (m.spd == 0) ? S_DWELL : S_SHIFT;
      end else if (m.st == S_IDLE) begin
         if (tgt != 0) n.st = S_RAMP;
      end else if (m.st == S_RUN) begin
         if (tgt != m.spd) n.st = S_RAMP;
      end else if (el % RT == 0) begin
         if (tgt > m.spd)      n.spd = m.spd + 1;
         else if (tgt < m.spd) n.spd = m.spd - 1;
         if (n.spd == tgt) n.st = (tgt == 0) ? S_IDLE : S_RUN;
      end
      if (n.st != m.st) n.entry = t;
      return n;
   endfunction

   function automatic int mbusy(input mdl_t m);
      return (m.st == S_RAMP || m.st == S_SHIFT || m.st == S_DWELL || m.st == S_ESTOP) ? 1 : 0;
   endfunction

   task automatic compare_all();
      check("a_speed", int'(speed_a), ma.spd);
      check("a_gear",  int'(gear_a),  ma.gear);
      check("a_state", int'(state_a), ma.st);
      check("a_busy",  int'(busy_a),  mbusy(ma));
      check("b_speed", int'(speed_b), mb.spd);
      check("b_gear",  int'(gear_b),  mb.gear);
      check("b_state", int'(state_b), mb.st);
      check("b_busy",  int'(busy_b),  mbusy(mb));
   endtask

   task automatic tick();
      @(posedge clk);
      now++;
      ma = mstep(ma, 15, now, rst_n, int'(target_level), int'(gear_req), estop);
      mb = mstep(mb, 12, now, rst_n, int'(target_level), int'(gear_req), estop);
      #1;
      compare_all();
   endtask

   initial begin
      ma = '{0, 0, 0, 0, 0};
      mb = '{0, 0, 0, 0, 0};
      rst_n        = 1'b0;
      target_level = 4'd0;
      gear_req     = 3'd0;
      estop        = 1'b0;

      // Reset state
      repeat (2) tick();
      check("rst_speed", int'(speed_a), 0);
      check("rst_gear",  int'(gear_a),  0);
      check("rst_state", int'(state_a), 0);
      check("rst_busy",  int'(busy_a),  0);
      rst_n = 1'b1;
      tick();

      // Ramp 0 -> 5: steps land at cycles 5, 9, 13, 17, 21
      target_level = 4'd5;
      for (int k = 1; k <= 21; k++) begin
         tick();
         if (k >= 5 && (k % 4) == 1) check("ramp_up_lit", int'(speed_a), (k - 1) / 4);
      end
      check("run_state_lit", int'(state_a), 1);
      check("run_busy_lit",  int'(busy_a),  0);

      // Gear change from RUN: five steps down, dwell of 8, commit, ramp back
      gear_req = 3'd2;
      repeat (21) tick();
      check("shift_zero_lit",  int'(speed_a), 0);
      check("shift_dwell_lit", int'(state_a), 4);
      repeat (7) tick();
      check("dwell_hold_gear_lit", int'(gear_a), 0);
      tick();
      check("commit_gear_lit",  int'(gear_a),  2);
      check("commit_state_lit", int'(state_a), 2);
      repeat (20) tick();
      check("reramp_speed_lit", int'(speed_a), 5);

      // Estop mid-ramp at speed 7, then resume from 0 toward the clamped ceiling
      target_level = 4'd15;
      repeat (9) tick();
      check("pre_estop_speed_lit", int'(speed_a), 7);
      estop = 1'b1;
      tick();
      check("estop_speed_lit", int'(speed_a), 0);
      check("estop_state_lit", int'(state_a), 5);
      check("estop_busy_lit",  int'(busy_a),  1);
      tick();
      estop = 1'b0;
      tick();
      check("estop_release_lit", int'(state_a), 0);
      tick();
      check("resume_ramp_lit", int'(state_a), 2);
      repeat (60) tick();
      check("max15_speed_lit", int'(speed_a), 15);
      check("max12_speed_lit", int'(speed_b), 12);
      check("max12_state_lit", int'(state_b), 1);

      // Gear requests during DWELL: last one wins, dwell length unchanged
      target_level = 4'd0;
      estop = 1'b1;
      tick();
      estop = 1'b0;
      tick();
      gear_req = 3'd3;
      tick();
      check("dwell_entry_lit", int'(state_a), 4);
      repeat (2) tick();
      gear_req = 3'd4;
      repeat (5) tick();
      check("dwell_last_state_lit", int'(state_a), 4);
      check("dwell_last_gear_lit",  int'(gear_a),  2);
      tick();
      check("dwell_commit_gear_lit",  int'(gear_a),  4);
      check("dwell_commit_state_lit", int'(state_a), 0);

      // Randomized traffic, including occasional estop pulses and mid-run resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) target_level = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) gear_req = 3'($urandom_range(0, 7));
         estop = ($urandom_range(0, 59) == 0);
         rst_n = ($urandom_range(0, 499) != 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
